// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq_if
// Description : Bundle between the ID stage (master) and the registered
//               ALU-control sequencer (slave).
//                 in_valid  m->s  instruction presented at ID/EX
//                 opcode    m->s  opcode class from main decoder
//                 funct     m->s  R-type funct field
//                 flush     m->s  synchronous pipeline flush
//                 operation s->m  registered ALU operation code
//                 op_valid  s->m  pulse: operation final for EX
//                 stall     s->m  long operation in progress
//                 illegal   s->m  pulse: undecodable R-type funct
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if #(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 6,
  parameter int OPER_W  = 4
) ();
  logic               in_valid;
  logic [OPC_W-1:0]   opcode;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic [OPER_W-1:0]  operation;
  logic               op_valid;
  logic               stall;
  logic               illegal;

  modport master (
    output in_valid, opcode, funct, flush,
    input  operation, op_valid, stall, illegal
  );

  modport slave (
    input  in_valid, opcode, funct, flush,
    output operation, op_valid, stall, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Registered ALU-control decode for the ID/EX boundary with a
//               multi-cycle sequencer for mult/div. Holds the operation code
//               stable and raises stall while a long operation runs.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - alu_ctrl_seq_if.slave (decode inputs, results)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 6,
  parameter int OPER_W  = 4,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Opcode classes
  localparam logic [OPC_W-1:0]   C_OPC_RTYPE = OPC_W'(2);
  localparam logic [OPC_W-1:0]   C_OPC_ADD   = OPC_W'(4);
  localparam logic [OPC_W-1:0]   C_OPC_AND   = OPC_W'(7);

  // R-type funct values
  localparam logic [FUNCT_W-1:0] C_FN_ADD    = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0] C_FN_SUB    = FUNCT_W'(6'h22);
  localparam logic [FUNCT_W-1:0] C_FN_AND    = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] C_FN_OR     = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] C_FN_SLT    = FUNCT_W'(6'h14);
  localparam logic [FUNCT_W-1:0] C_FN_MULT   = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] C_FN_DIV    = FUNCT_W'(6'h1A);

  // ALU operation codes, zero-extended to OPER_W
  localparam logic [OPER_W-1:0]  C_OP_NONE   = OPER_W'(0);
  localparam logic [OPER_W-1:0]  C_OP_OR     = OPER_W'(3);
  localparam logic [OPER_W-1:0]  C_OP_ADD    = OPER_W'(4);
  localparam logic [OPER_W-1:0]  C_OP_SLT    = OPER_W'(5);
  localparam logic [OPER_W-1:0]  C_OP_SUB    = OPER_W'(6);
  localparam logic [OPER_W-1:0]  C_OP_AND    = OPER_W'(7);
  localparam logic [OPER_W-1:0]  C_OP_MULT   = OPER_W'(8);
  localparam logic [OPER_W-1:0]  C_OP_DIV    = OPER_W'(9);

  localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   C_CYC_MUL   = CNT_W'(MUL_CYC);
  localparam logic [CNT_W-1:0]   C_CYC_DIV   = CNT_W'(DIV_CYC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LONG = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [OPER_W-1:0]   r_operation;
  logic [OPER_W-1:0]   w_operation_nxt;
  logic                r_op_valid;
  logic                w_op_valid_nxt;
  logic                r_stall;
  logic                w_stall_nxt;
  logic                r_illegal;
  logic                w_illegal_nxt;

  // Decode results
  logic [OPER_W-1:0]   w_code;
  logic                w_illegal;
  logic                w_long;
  logic [CNT_W-1:0]    w_cyc;

  // --------------------------------------------------------------------------
  // Combinational decode: every input pattern maps to a defined code.
  // --------------------------------------------------------------------------
  always_comb begin
    w_code    = C_OP_NONE;
    w_illegal = 1'b0;
    w_long    = 1'b0;
    w_cyc     = C_CNT_ONE;
    if (bus.opcode == C_OPC_ADD) begin
      w_code = C_OP_ADD;
    end else if (bus.opcode == C_OPC_AND) begin
      w_code = C_OP_AND;
    end else if (bus.opcode == C_OPC_RTYPE) begin
      case (bus.funct)
        C_FN_ADD:  w_code = C_OP_ADD;
        C_FN_SUB:  w_code = C_OP_SUB;
        C_FN_AND:  w_code = C_OP_AND;
        C_FN_OR:   w_code = C_OP_OR;
        C_FN_SLT:  w_code = C_OP_SLT;
        C_FN_MULT: begin
          w_code = C_OP_MULT;
          w_long = 1'b1;
          w_cyc  = C_CYC_MUL;
        end
        C_FN_DIV: begin
          w_code = C_OP_DIV;
          w_long = 1'b1;
          w_cyc  = C_CYC_DIV;
        end
        default: begin
          w_code    = C_OP_NONE;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed here and
  // registered below so nothing reaches the bus combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_operation_nxt = r_operation;
    w_op_valid_nxt  = 1'b0;
    w_stall_nxt     = r_stall;
    w_illegal_nxt   = 1'b0;

    if (bus.flush) begin
      // Flush wins over a simultaneous in_valid; the instruction is dropped.
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_operation_nxt = C_OP_NONE;
      w_stall_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_stall_nxt = 1'b0;
          if (bus.in_valid) begin
            w_operation_nxt = w_code;
            // A long op configured for a single cycle completes like a short op.
            if (w_long && (w_cyc > C_CNT_ONE)) begin
              w_state_nxt = ST_LONG;
              w_cnt_nxt   = w_cyc - C_CNT_ONE;
              w_stall_nxt = 1'b1;
            end else begin
              w_op_valid_nxt = 1'b1;
              w_illegal_nxt  = w_illegal;
            end
          end
        end
        ST_LONG: begin
          // in_valid is ignored here; upstream is held by stall.
          if (r_cnt == C_CNT_ONE) begin
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = '0;
            w_stall_nxt    = 1'b0;
            w_op_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = '0;
          w_operation_nxt = C_OP_NONE;
          w_stall_nxt     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_operation <= C_OP_NONE;
      r_op_valid  <= 1'b0;
      r_stall     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_operation <= w_operation_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_stall     <= w_stall_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  assign bus.operation = r_operation;
  assign bus.op_valid  = r_op_valid;
  assign bus.stall     = r_stall;
  assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Self-checking bench for alu_ctrl_seq. A main instance with
//               MUL_CYC=4/DIV_CYC=16 and a second instance with MUL_CYC=1
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       tb_in_valid;
  logic [3:0] tb_opcode;
  logic [5:0] tb_funct;
  logic       tb_flush;

  int n_chk;
  int n_fail;

  alu_ctrl_seq_if #(.OPC_W(4), .FUNCT_W(6), .OPER_W(4)) bus0 ();
  alu_ctrl_seq_if #(.OPC_W(4), .FUNCT_W(6), .OPER_W(4)) bus1 ();

  assign bus0.in_valid = tb_in_valid;
  assign bus0.opcode   = tb_opcode;
  assign bus0.funct    = tb_funct;
  assign bus0.flush    = tb_flush;
  assign bus1.in_valid = tb_in_valid;
  assign bus1.opcode   = tb_opcode;
  assign bus1.funct    = tb_funct;
  assign bus1.flush    = tb_flush;

  alu_ctrl_seq #(
    .OPC_W(4), .FUNCT_W(6), .OPER_W(4), .MUL_CYC(4), .DIV_CYC(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  alu_ctrl_seq #(
    .OPC_W(4), .FUNCT_W(6), .OPER_W(4), .MUL_CYC(1), .DIV_CYC(16)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] opc;
    logic [5:0] fn;
    logic       fl;
    logic [3:0] op;
    logic       v;
    logic       s;
    logic       il;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic iv, input logic [3:0] opc,
                              input logic [5:0] fn, input logic fl,
                              input logic [3:0] op, input logic v,
                              input logic s, input logic il);
    vec_t r;
    r.iv = iv; r.opc = opc; r.fn = fn; r.fl = fl;
    r.op = op; r.v = v; r.s = s; r.il = il;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk0(input string nm, input logic [3:0] op, input logic v,
                      input logic s, input logic il);
    chk({nm, ".operation"}, 32'(bus0.operation), 32'(op));
    chk({nm, ".op_valid"},  32'(bus0.op_valid),  32'(v));
    chk({nm, ".stall"},     32'(bus0.stall),     32'(s));
    chk({nm, ".illegal"},   32'(bus0.illegal),   32'(il));
  endtask

  task automatic chk1(input string nm, input logic [3:0] op, input logic v,
                      input logic s, input logic il);
    chk({nm, ".operation"}, 32'(bus1.operation), 32'(op));
    chk({nm, ".op_valid"},  32'(bus1.op_valid),  32'(v));
    chk({nm, ".stall"},     32'(bus1.stall),     32'(s));
    chk({nm, ".illegal"},   32'(bus1.illegal),   32'(il));
  endtask

  task automatic drive(input logic iv, input logic [3:0] opc,
                       input logic [5:0] fn, input logic fl);
    tb_in_valid = iv;
    tb_opcode   = opc;
    tb_funct    = fn;
    tb_flush    = fl;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 4'h0, 6'h00, 1'b0);

    //          iv  opc   fn     fl    op    v     s     il
    vt[0]  = mk(1, 4'h2, 6'h25, 0,   4'h3, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(1, 4'h4, 6'h00, 0,   4'h4, 1'b1, 1'b0, 1'b0);
    vt[2]  = mk(1, 4'h7, 6'h00, 0,   4'h7, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(0, 4'h4, 6'h00, 0,   4'h7, 1'b0, 1'b0, 1'b0);
    vt[4]  = mk(1, 4'h2, 6'h3F, 0,   4'h0, 1'b1, 1'b0, 1'b1);
    vt[5]  = mk(0, 4'h2, 6'h3F, 0,   4'h0, 1'b0, 1'b0, 1'b0);
    vt[6]  = mk(1, 4'h5, 6'h00, 0,   4'h0, 1'b1, 1'b0, 1'b0);
    vt[7]  = mk(1, 4'h2, 6'h22, 0,   4'h6, 1'b1, 1'b0, 1'b0);
    vt[8]  = mk(1, 4'h2, 6'h24, 0,   4'h7, 1'b1, 1'b0, 1'b0);
    vt[9]  = mk(1, 4'h2, 6'h14, 0,   4'h5, 1'b1, 1'b0, 1'b0);
    vt[10] = mk(1, 4'h2, 6'h20, 0,   4'h4, 1'b1, 1'b0, 1'b0);
    vt[11] = mk(1, 4'h4, 6'h00, 1,   4'h0, 1'b0, 1'b0, 1'b0);
    // mult, 4 cycles: three stall cycles, then op_valid; div issued in that cycle
    vt[12] = mk(1, 4'h2, 6'h18, 0,   4'h8, 1'b0, 1'b1, 1'b0);
    vt[13] = mk(1, 4'h4, 6'h00, 0,   4'h8, 1'b0, 1'b1, 1'b0);
    vt[14] = mk(0, 4'h0, 6'h00, 0,   4'h8, 1'b0, 1'b1, 1'b0);
    vt[15] = mk(1, 4'h7, 6'h00, 0,   4'h8, 1'b1, 1'b0, 1'b0);
    vt[16] = mk(1, 4'h2, 6'h1A, 0,   4'h9, 1'b0, 1'b1, 1'b0);

    // Reset state
    step();
    chk0("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].iv, vt[i].opc, vt[i].fn, vt[i].fl);
      step();
      chk0($sformatf("row%0d", i), vt[i].op, vt[i].v, vt[i].s, vt[i].il);
    end

    // Remaining 14 stall cycles of the div; in_valid must be ignored.
    drive(1'b1, 4'h4, 6'h00, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step();
      chk0($sformatf("div_stall%0d", i + 2), 4'h9, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk0("div_done", 4'h9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    step();
    chk0("div_hold", 4'h9, 1'b0, 1'b0, 1'b0);

    // Flush in the 2nd stall cycle of a div.
    drive(1'b1, 4'h2, 6'h1A, 1'b0);
    step();
    chk0("fl_div_s1", 4'h9, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    step();
    chk0("fl_div_s2", 4'h9, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b1);
    step();
    chk0("fl_after", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 6'h20, 1'b0);
    step();
    chk0("fl_add", 4'h4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    step();
    chk0("fl_idle", 4'h4, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a mult.
    drive(1'b1, 4'h2, 6'h18, 1'b0);
    step();
    chk0("rst_mul_s1", 4'h8, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk0("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk0("rst_held", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'h7, 6'h00, 1'b0);
    step();
    chk0("rst_short", 4'h7, 1'b1, 1'b0, 1'b0);

    // MUL_CYC=1 instance: mult completes like a short op.
    drive(1'b1, 4'h2, 6'h18, 1'b0);
    step();
    chk1("m1_mult", 4'h8, 1'b1, 1'b0, 1'b0);
    chk0("m4_mult", 4'h8, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'h2, 6'h25, 1'b1);
    step();
    chk1("m1_flush", 4'h0, 1'b0, 1'b0, 1'b0);
    chk0("m4_flush", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 6'h18, 1'b0);
    step();
    chk1("m1_mult2", 4'h8, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 6'h00, 1'b1);
    step();
    chk1("m1_fl_iv", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    step();
    chk1("m1_idle", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU-control unit for the ID/EX boundary of the pipelined MIPS core. It decodes the 4-bit main-decoder opcode class and the R-type funct field into an ALU operation code. It also sequences multi-cycle multiply/divide operations with an internal down-counter and a pipeline stall output. It replaces the purely combinational ALU-control decode and holds the operation code stable for the whole duration of a long operation.

## Interface
- `OPC_W`, 4, width of main-decoder opcode class
- `FUNCT_W`, 6, width of funct field
- `OPER_W`, 4, width of ALU operation code
- `MUL_CYC`, 4, total cycles for mult (≥1)
- `DIV_CYC`, 16, total cycles for div (≥1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction presented at ID/EX
- `opcode`  in  OPC_W  opcode class from main decoder
- `funct`  in  FUNCT_W  R-type funct field
- `flush`  in  1  synchronous pipeline flush
- `operation`  out  OPER_W  registered ALU operation code
- `op_valid`  out  1  one-cycle pulse: `operation` is final for the EX stage
- `stall`  out  1  long operation in progress; upstream holds its inputs
- `illegal`  out  1  one-cycle pulse: undecodable R-type funct

## Operation
- Decode, with values in hex:
  - opcode 4 → 4 (add)
  - opcode 7 → 7 (and)
  - opcode 2 (R-type), by funct:
    - 20 → 4
    - 22 → 6 (sub)
    - 24 → 7
    - 25 → 3 (or)
    - 14 → 5
    - 18 → 8 (mult, long, MUL_CYC)
    - 1A → 9 (div, long, DIV_CYC)
  - any other funct with opcode 2 → 0 plus `illegal`
  - any other opcode → 0, no `illegal`
- Codes are zero-extended to OPER_W.
- The decode has no latches. Every input combination yields a defined code.
- States are IDLE and LONG. The counter width is clog2(max(MUL_CYC,DIV_CYC)+1).
- IDLE, `in_valid`=1, short op or long op with CYC=1:
  - at the next edge, `operation`=code and `op_valid`=1 for one cycle
  - the state stays IDLE
- IDLE, `in_valid`=1, long op with CYC>1:
  - at the next edge, `operation`=code, cnt=CYC-1, `stall`=1, `op_valid`=0
  - the state goes to LONG
- LONG:
  - cnt decrements each edge.
  - At the edge where cnt==1: the state goes to IDLE, cnt=0, `stall`=0, `op_valid`=1 for one cycle.
  - `operation` is held unchanged throughout LONG.
- `in_valid` is ignored while in LONG (`stall`=1).
- IDLE, `in_valid`=0: `op_valid`=0 and `illegal`=0. `operation` holds its last value.
- `flush`=1 at an edge, in any state:
  - the state goes to IDLE; cnt=0, `operation`=0, `op_valid`=0, `stall`=0, `illegal`=0
  - `flush` has priority over a simultaneous `in_valid`, which is dropped
- Reset, async, at any time including mid-LONG: the state is IDLE, cnt=0, and every output is 0.

## Timing
- Short op latency is 1 cycle, from the `in_valid` edge to `op_valid`.
- Long op:
  - `stall` is high for exactly CYC-1 cycles.
  - `op_valid` rises CYC cycles after the issue edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- In the cycle `op_valid`=1 after a long op, the state is IDLE and a new `in_valid` is accepted. Back-to-back long ops therefore have no idle gap.
- Back-to-back short ops give one result per cycle.
- `illegal` and `op_valid` pulse in the same cycle.

## Test plan
- Reset, then `in_valid` with opcode 2/funct 25, then opcode 4, then opcode 7 in consecutive cycles → `operation` 3, 4, 7 on successive cycles, each with `op_valid`=1 and `stall`=0.
- Opcode 2/funct 18 with MUL_CYC=4 → `stall`=1 for 3 cycles, `operation`=8 held throughout, `op_valid` on the 4th cycle. Issuing funct 1A in that same cycle → `stall` for 15 cycles, `operation`=9.
- Opcode 2/funct 3F → `operation`=0, `op_valid`=1, `illegal`=1 for one cycle. Opcode 5 → `operation`=0, `illegal`=0.
- `flush` in the 2nd stall cycle of a div → next cycle IDLE, all outputs 0. A following funct 20 → `operation`=4 after 1 cycle.
- `rst_n` low mid-LONG → outputs 0 immediately, without waiting for `clk`. After release, a short op behaves normally.
- `flush` and `in_valid` in the same cycle → instruction dropped, `op_valid`=0. Repeat the checks with MUL_CYC=1 → mult behaves as short (no `stall`).
